// File: rtl/decode_ctrl.sv
// Two-stage decode/control: instruction register plus registered control word, with flush.
// Define DECODE_HAZARD_STALL_EN to enable RAW hazard detection and single-cycle stall.
module decode_ctrl #(
  parameter logic [15:0] NOP_WORD = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr_in,
  input  logic        instr_valid,
  input  logic        branch_taken,
  output logic        pc_hold,
  output logic [2:0]  da,
  output logic [2:0]  aa,
  output logic [2:0]  ba,
  output logic [5:0]  imm,
  output logic        cs,
  output logic        ma,
  output logic        mb,
  output logic [1:0]  md,
  output logic [4:0]  fs,
  output logic        rw,
  output logic        mw,
  output logic [1:0]  bs,
  output logic        ps,
  output logic        illegal_op
);

  typedef struct packed {
    logic [2:0] da;
    logic [2:0] aa;
    logic [2:0] ba;
    logic [5:0] imm;
    logic       cs;
    logic       ma;
    logic       mb;
    logic [1:0] md;
    logic [4:0] fs;
    logic       rw;
    logic       mw;
    logic [1:0] bs;
    logic       ps;
  } cw_t;

  localparam cw_t Bubble = '0;

  localparam logic [6:0] OpNop = 7'b0000000;
  localparam logic [6:0] OpAdd = 7'b0000010;
  localparam logic [6:0] OpSub = 7'b0000101;
  localparam logic [6:0] OpAnd = 7'b0001000;
  localparam logic [6:0] OpOr  = 7'b0001001;
  localparam logic [6:0] OpXor = 7'b0001010;
  localparam logic [6:0] OpAdi = 7'b0100010;
  localparam logic [6:0] OpLdi = 7'b1001100;
  localparam logic [6:0] OpLd  = 7'b0010000;
  localparam logic [6:0] OpIn  = 7'b0010001;
  localparam logic [6:0] OpSt  = 7'b0100000;
  localparam logic [6:0] OpBz  = 7'b1100000;
  localparam logic [6:0] OpBnz = 7'b1001000;
  localparam logic [6:0] OpJmr = 7'b1110000;
  localparam logic [6:0] OpJmp = 7'b1101000;
  localparam logic [6:0] OpJml = 7'b0110000;

  logic [15:0] ir_q, ir_d;
  cw_t         cw_q, cw_d, dec;
  logic        dec_illegal;
  logic        illegal_q, illegal_d;
  logic        stall;
  logic [6:0]  opcode;

  assign opcode = ir_q[15:9];

  always_comb begin
    dec             = Bubble;
    dec_illegal     = 1'b0;
    dec.da          = ir_q[8:6];
    dec.aa          = ir_q[5:3];
    dec.ba          = ir_q[2:0];
    dec.imm         = ir_q[5:0];
    case (opcode)
      OpNop: dec.rw = 1'b0;
      OpAdd: begin
        dec.fs = 5'b00010;
        dec.rw = 1'b1;
      end
      OpSub: begin
        dec.fs = 5'b00101;
        dec.rw = 1'b1;
      end
      OpAnd: begin
        dec.fs = 5'b01000;
        dec.rw = 1'b1;
      end
      OpOr: begin
        dec.fs = 5'b01001;
        dec.rw = 1'b1;
      end
      OpXor: begin
        dec.fs = 5'b01010;
        dec.rw = 1'b1;
      end
      OpAdi: begin
        dec.fs = 5'b00010;
        dec.mb = 1'b1;
        dec.cs = 1'b1;
        dec.rw = 1'b1;
      end
      OpLdi: begin
        dec.fs = 5'b01100;
        dec.mb = 1'b1;
        dec.rw = 1'b1;
      end
      OpLd: begin
        dec.md = 2'b01;
        dec.rw = 1'b1;
      end
      OpIn: begin
        dec.md = 2'b10;
        dec.rw = 1'b1;
      end
      OpSt: dec.mw = 1'b1;
      OpBz: begin
        dec.bs = 2'b01;
        dec.mb = 1'b1;
        dec.cs = 1'b1;
      end
      OpBnz: begin
        dec.bs = 2'b01;
        dec.ps = 1'b1;
        dec.mb = 1'b1;
        dec.cs = 1'b1;
      end
      OpJmr: dec.bs = 2'b10;
      OpJmp: begin
        dec.bs = 2'b11;
        dec.mb = 1'b1;
        dec.cs = 1'b1;
      end
      OpJml: begin
        // Link register is always R7.
        dec.bs = 2'b11;
        dec.ma = 1'b1;
        dec.mb = 1'b1;
        dec.cs = 1'b1;
        dec.rw = 1'b1;
        dec.da = 3'd7;
      end
      default: begin
        dec         = Bubble;
        dec_illegal = 1'b1;
      end
    endcase
  end

`ifdef DECODE_HAZARD_STALL_EN
  logic reads_a, reads_b;

  always_comb begin
    reads_a = ~dec_illegal;
    reads_b = 1'b0;
    case (opcode)
      OpNop, OpLdi, OpIn, OpJmp:                 reads_a = 1'b0;
      OpAdd, OpSub, OpAnd, OpOr, OpXor, OpSt:    reads_b = 1'b1;
      default:                                   reads_b = 1'b0;
    endcase
  end

  // R0 is never a real destination, so writes to it cannot create a hazard.
  assign stall = cw_q.rw && (cw_q.da != 3'd0) &&
                 ((reads_a && (dec.aa == cw_q.da)) || (reads_b && (dec.ba == cw_q.da)));
`else
  assign stall = 1'b0;
`endif

  assign pc_hold = stall && !branch_taken;

  always_comb begin
    ir_d      = ir_q;
    cw_d      = dec;
    illegal_d = dec_illegal;
    if (branch_taken) begin
      ir_d      = NOP_WORD;
      cw_d      = Bubble;
      illegal_d = 1'b0;
    end else if (stall) begin
      cw_d      = Bubble;
      illegal_d = 1'b0;
    end else begin
      ir_d = instr_valid ? instr_in : NOP_WORD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q      <= NOP_WORD;
      cw_q      <= Bubble;
      illegal_q <= 1'b0;
    end else begin
      ir_q      <= ir_d;
      cw_q      <= cw_d;
      illegal_q <= illegal_d;
    end
  end

  assign da         = cw_q.da;
  assign aa         = cw_q.aa;
  assign ba         = cw_q.ba;
  assign imm        = cw_q.imm;
  assign cs         = cw_q.cs;
  assign ma         = cw_q.ma;
  assign mb         = cw_q.mb;
  assign md         = cw_q.md;
  assign fs         = cw_q.fs;
  assign rw         = cw_q.rw;
  assign mw         = cw_q.mw;
  assign bs         = cw_q.bs;
  assign ps         = cw_q.ps;
  assign illegal_op = illegal_q;

endmodule
